// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory bus between instruction fetch and the memory stage.
// Data accesses win ties; a streak counter guarantees a waiting fetch is eventually served.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_kill,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                m_req,
   input  logic                m_we,
   input  logic [ADDR_W-1:0]   m_addr,
   input  logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W/8-1:0] m_be,
   output logic [DATA_W-1:0]   m_rdata,
   output logic                m_valid,
   output logic                stall_mem,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          streak_q, streak_d;
   logic                kill_pend_q, kill_pend_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic                if_valid_q, if_valid_d;
   logic                m_valid_q, m_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         kill_pend_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_valid_q  <= 1'b0;
         m_valid_q   <= 1'b0;
         if_rdata_q  <= '0;
         m_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         kill_pend_q <= kill_pend_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_valid_q  <= if_valid_d;
         m_valid_q   <= m_valid_d;
         if_rdata_q  <= if_rdata_d;
         m_rdata_q   <= m_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      kill_pend_d = kill_pend_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_valid_d  = 1'b0;
      m_valid_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      m_rdata_d   = m_rdata_q;
      case (state_q)
         IDLE: begin
            kill_pend_d = 1'b0;
            if (m_req && (!if_req || streak_q < STREAK_MAX)) begin
               state_d     = D_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = m_we;
               mem_addr_d  = m_addr;
               mem_wdata_d = m_wdata;
               mem_be_d    = m_be;
               if (!if_req) begin
                  streak_d = '0;
               end else if (streak_q < STREAK_MAX) begin
                  streak_d = streak_q + 4'd1;
               end
            end else if (if_req && !if_kill) begin
               state_d     = I_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               streak_d    = '0;
            end
         end
         D_BUSY, I_BUSY: begin
            if (state_q == I_BUSY && if_kill) begin
               kill_pend_d = 1'b1;
            end
            // The valid flop is loaded on the ack edge so the pulse lands in RESP.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               if (state_q == I_BUSY) begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = !kill_pend_q && !if_kill;
               end else begin
                  m_valid_d = 1'b1;
                  if (!mem_we_q) begin
                     m_rdata_d = mem_rdata;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_valid  = if_valid_q;
   assign m_valid   = m_valid_q;
   assign if_rdata  = if_rdata_q;
   assign m_rdata   = m_rdata_q;
   assign stall_mem = m_req & ~m_valid_q;
   assign if_stall  = if_req & ~if_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MAXS = 4;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_kill;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_be;
   logic [DW-1:0] m_rdata;
   logic          m_valid;
   logic          stall_mem;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_rdata(m_rdata), .m_valid(m_valid), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Memory responder: acks after a programmable or random wait, optional spurious acks while idle.
   int            fixed_wait = 0;
   bit            fixed_rdata_en = 1'b0;
   logic [DW-1:0] fixed_rdata = '0;
   bit            spurious_en = 1'b0;
   int            resp_wait = 0;
   bit            in_txn = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         mem_ack = 1'b0;
         in_txn = 1'b0;
      end else if (mem_req) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            resp_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
         end
         if (resp_wait == 0) begin
            mem_ack = 1'b1;
            mem_rdata = fixed_rdata_en ? fixed_rdata : DW'($urandom);
            in_txn = 1'b0;
         end else begin
            mem_ack = 1'b0;
            resp_wait--;
         end
      end else begin
         in_txn = 1'b0;
         mem_ack = spurious_en && ($urandom_range(0, 7) == 0);
         mem_rdata = DW'($urandom);
      end
   end

   // Reference model: who owns the bus, whether a response is being returned, and the data streak.
   int            owner;
   bit            responding;
   bit            killed;
   int            streak;
   logic          exp_mem_req, exp_mem_we, exp_if_valid, exp_m_valid;
   logic [AW-1:0] exp_mem_addr;
   logic [DW-1:0] exp_mem_wdata, exp_if_rdata, exp_m_rdata;
   logic [BW-1:0] exp_mem_be;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         owner = 0; responding = 1'b0; killed = 1'b0; streak = 0;
         exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
         exp_mem_be = '0; exp_if_valid = 1'b0; exp_m_valid = 1'b0;
         exp_if_rdata = '0; exp_m_rdata = '0;
      end else begin
         exp_if_valid = 1'b0;
         exp_m_valid = 1'b0;
         if (owner != 0) begin
            if (owner == 2 && if_kill) killed = 1'b1;
            if (mem_ack) begin
               exp_mem_req = 1'b0;
               if (owner == 1) begin
                  exp_m_valid = 1'b1;
                  if (!exp_mem_we) exp_m_rdata = mem_rdata;
               end else begin
                  exp_if_rdata = mem_rdata;
                  exp_if_valid = !killed;
               end
               owner = 0;
               responding = 1'b1;
            end
         end else if (responding) begin
            responding = 1'b0;
            killed = 1'b0;
         end else begin
            killed = 1'b0;
            if (m_req && (!if_req || streak < MAXS)) begin
               owner = 1;
               streak = if_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
               exp_mem_req = 1'b1; exp_mem_we = m_we; exp_mem_addr = m_addr;
               exp_mem_wdata = m_wdata; exp_mem_be = m_be;
            end else if (if_req && !if_kill) begin
               owner = 2;
               streak = 0;
               exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = if_addr;
               exp_mem_be = '1;
            end
         end
      end
   end

   // Every cycle, shortly after the edge, the DUT outputs must match the model.
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         checkOutput("mem_req", 64'(mem_req), 64'(exp_mem_req));
         checkOutput("m_valid", 64'(m_valid), 64'(exp_m_valid));
         checkOutput("if_valid", 64'(if_valid), 64'(exp_if_valid));
         checkOutput("m_rdata", 64'(m_rdata), 64'(exp_m_rdata));
         checkOutput("stall_mem", 64'(stall_mem), 64'(m_req && !exp_m_valid));
         checkOutput("if_stall", 64'(if_stall), 64'(if_req && !exp_if_valid));
         if (exp_mem_req) begin
            checkOutput("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
            checkOutput("mem_we", 64'(mem_we), 64'(exp_mem_we));
            checkOutput("mem_be", 64'(mem_be), 64'(exp_mem_be));
            if (exp_mem_we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(exp_mem_wdata));
         end
         if (exp_if_valid) checkOutput("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      end
   end

   task automatic idleInputs();
      if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
   endtask

   // One cycle of random requester behaviour, called at each falling edge.
   task automatic applyStimulus();
      if_kill = 1'b0;
      if (!m_req) begin
         if ($urandom_range(0, 3) == 0) begin
            m_req = 1'b1; m_we = 1'($urandom); m_addr = $urandom;
            m_wdata = $urandom; m_be = BW'($urandom);
         end
      end else if (m_valid) begin
         if ($urandom_range(0, 1) == 0) begin
            m_we = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_be = BW'($urandom);
         end else begin
            m_req = 1'b0;
         end
      end
      if (!if_req) begin
         if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
         end
      end else if (if_valid) begin
         if ($urandom_range(0, 1) == 0) if_addr = $urandom;
         else if_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
         if_kill = 1'b1;
         if_addr = $urandom;
      end
   endtask

   initial begin
      int valid_cyc;
      int pulses;
      int issues;
      logic prev_req;
      string grants;
      string exp_order;

      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      idleInputs();
      #1;
      checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset_m_rdata", 64'(m_rdata), 64'd0);
      checkOutput("reset_if_valid", 64'(if_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single load, ack on the second bus cycle.
      @(negedge clk);
      fixed_wait = 1; fixed_rdata_en = 1'b1; fixed_rdata = 32'hDEADBEEF;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h100;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #2;
         checkOutput("load_m_valid", 64'(m_valid), 64'(c == 3));
         checkOutput("load_stall_mem", 64'(stall_mem), 64'(c != 3));
         checkOutput("load_mem_req", 64'(mem_req), 64'(c != 3));
         if (c != 3) checkOutput("load_mem_addr", 64'(mem_addr), 64'h100);
      end
      checkOutput("load_m_rdata", 64'(m_rdata), 64'hDEADBEEF);
      @(negedge clk);
      m_req = 1'b0;

      // Store with ten wait states; request held through the response cycle and one more edge.
      repeat (2) @(negedge clk);
      fixed_wait = 10; fixed_rdata = 32'h5555AAAA;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h200; m_wdata = 32'h1234; m_be = 4'b0011;
      valid_cyc = 0; pulses = 0; issues = 0; prev_req = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #2;
         if (mem_req && !prev_req) issues++;
         prev_req = mem_req;
         if (mem_req) begin
            checkOutput("store_mem_we", 64'(mem_we), 64'd1);
            checkOutput("store_mem_be", 64'(mem_be), 64'b0011);
            checkOutput("store_mem_wdata", 64'(mem_wdata), 64'h1234);
            checkOutput("store_mem_addr", 64'(mem_addr), 64'h200);
         end
         if (m_valid) begin
            pulses++;
            valid_cyc = c;
            checkOutput("store_m_rdata_kept", 64'(m_rdata), 64'hDEADBEEF);
         end
         if (valid_cyc != 0 && c == valid_cyc + 1) begin
            @(negedge clk);
            m_req = 1'b0; m_we = 1'b0;
         end
      end
      checkOutput("store_valid_cycle", 64'(valid_cyc), 64'd12);
      checkOutput("store_valid_pulses", 64'(pulses), 64'd1);
      checkOutput("store_issues", 64'(issues), 64'd1);

      // Fetch killed while the bus access is in flight.
      @(negedge clk);
      fixed_wait = 3; fixed_rdata = 32'hBADC0DE0;
      if_req = 1'b1; if_addr = 32'h80000040;
      @(negedge clk);
      if_kill = 1'b1; if_req = 1'b0;
      @(negedge clk);
      if_kill = 1'b0;
      pulses = 0; issues = 0; prev_req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #2;
         if (if_valid) pulses++;
         if (mem_req && !prev_req) issues++;
         prev_req = mem_req;
      end
      checkOutput("kill_if_valid_pulses", 64'(pulses), 64'd0);
      checkOutput("kill_reissues", 64'(issues), 64'd0);
      @(negedge clk);
      fixed_wait = 0; fixed_rdata = 32'h00000013;
      if_req = 1'b1; if_addr = 32'h80000080;
      valid_cyc = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #2;
         if (c == 1) checkOutput("refetch_mem_addr", 64'(mem_addr), 64'h80000080);
         if (if_valid && valid_cyc == 0) begin
            valid_cyc = c;
            checkOutput("refetch_if_rdata", 64'(if_rdata), 64'h13);
            @(negedge clk);
            if_req = 1'b0;
         end
      end
      checkOutput("refetch_valid_cycle", 64'(valid_cyc), 64'd2);

      // Reset asserted while a load is outstanding.
      @(negedge clk);
      fixed_wait = 10;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h300;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst_mid_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_mid_if_valid", 64'(if_valid), 64'd0);
      @(negedge clk);
      idleInputs();
      @(negedge clk);
      rst = 1'b0;

      // Continuous contention from a clean streak: four data grants, then one fetch.
      @(negedge clk);
      fixed_wait = 0; fixed_rdata_en = 1'b0;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h10000000;
      if_req = 1'b1; if_addr = 32'h80000000;
      grants = ""; prev_req = 1'b0;
      for (int c = 0; c < 60 && grants.len() < 10; c++) begin
         @(posedge clk); #2;
         if (mem_req && !prev_req) grants = {grants, (mem_addr[31:28] == 4'h1) ? "D" : "I"};
         prev_req = mem_req;
         @(negedge clk);
         if (m_valid) m_addr = m_addr + 32'd1;
         if (if_valid) if_addr = if_addr + 32'd4;
      end
      exp_order = "DDDDIDDDDI";
      checkOutput("contention_grant_count", 64'(grants.len()), 64'd10);
      for (int i = 0; i < 10 && i < grants.len(); i++) begin
         checkOutput($sformatf("contention_grant_%0d", i), 64'(grants[i]), 64'(exp_order[i]));
      end
      idleInputs();
      repeat (4) @(negedge clk);

      // Randomized traffic with random wait states and stray acks.
      fixed_wait = -1; spurious_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         applyStimulus();
      end
      @(negedge clk);
      idleInputs();
      spurious_en = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported instruction/data memory bus between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sequences each access with a req/ack handshake and generates the fetch and memory-stage stall signals.
- Sits between fetch/memory stages and the memory interface.
- Gives data accesses priority, with a bounded streak counter so fetch is never starved.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_DATA_STREAK, 4, max consecutive data grants while a fetch is waiting (1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch requests an instruction read; held until if_valid or if_kill
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_kill  in  1  branch-taken flush; pending or in-flight fetch result is discarded
- if_rdata  out  DATA_W  instruction word; meaningful only when if_valid is high
- if_valid  out  1  one-cycle pulse: instruction returned
- if_stall  out  1  fetch must hold
- m_req  in  1  memory stage requests an access; held until m_valid
- m_we  in  1  1 = store, 0 = load
- m_addr  in  ADDR_W  word address (bank bits passed through unchanged)
- m_wdata  in  DATA_W  store data
- m_be  in  DATA_W/8  byte enables for stores
- m_rdata  out  DATA_W  load data (full word; lane select is done in writeback)
- m_valid  out  1  one-cycle pulse: access complete
- stall_mem  out  1  memory stage must stall
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_be  out  DATA_W/8  bus byte enables
- mem_ack  in  1  one-cycle: access done; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  bus read data

Behaviour:
- Reset values: state = IDLE; every registered output is 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid, m_valid, if_rdata, m_rdata); streak = 0; kill_pend = 0.
- Reset asserted mid-access abandons the transaction immediately. The memory side is reset in the same domain.
- FSM states: IDLE, D_BUSY, I_BUSY, RESP.
- IDLE:
  - If m_req and (!if_req or streak < MAX_DATA_STREAK), go to D_BUSY.
  - Else if if_req and !if_kill, go to I_BUSY.
  - Else stay in IDLE.
  - On entry to a BUSY state, register mem_req = 1 and mem_addr/we/wdata/be from the winner. Fetch always drives we = 0 and be = all-ones.
- Streak rule:
  - A data grant while if_req is high increments streak, saturating at MAX_DATA_STREAK.
  - A data grant with if_req low clears streak.
  - An instruction grant clears streak.
- D_BUSY / I_BUSY:
  - Hold mem_* stable until mem_ack.
  - On mem_ack: mem_req goes to 0 next cycle, mem_rdata is latched into m_rdata or if_rdata, and the state goes to RESP.
- RESP (1 cycle):
  - Pulse m_valid, or pulse if_valid if the access was a fetch and !kill_pend and !if_kill.
  - Next state is IDLE. Requests are not sampled in RESP, so a requester that keeps req high for one extra cycle is not reissued.
- Latency: request sampled in IDLE at cycle N, mem_req high at N+1, ack at N+k, valid at N+k+1. Minimum is 3 cycles per access with zero-wait memory (ack in first mem_req cycle).
- if_kill:
  - In IDLE, the fetch is not granted.
  - In I_BUSY, the bus transaction completes (never aborted) but kill_pend is set and if_valid is suppressed.
  - kill_pend clears on return to IDLE.
- stall_mem = m_req & !m_valid (combinational).
- if_stall = if_req & !if_valid (combinational). Both are 0 in the cycle their valid is high.
- Simultaneous m_req and if_req with streak below the limit: data wins.
- Writes: m_rdata is not updated (keeps its old value); m_valid still pulses.
- mem_ack outside BUSY states is ignored.

Test Plan:
- Single load: m_req=1, m_addr=0x100, mem_ack at 2nd mem_req cycle with mem_rdata=0xDEADBEEF -> m_valid one cycle at cycle 4 with m_rdata=0xDEADBEEF; stall_mem high cycles 1–3, low at 4.
- Store: m_we=1, m_be=4'b0011, m_wdata=0x1234 -> mem_we=1, mem_be=0011, mem_wdata=0x1234 held until ack; m_valid pulses; m_rdata unchanged.
- Contention and starvation bound: if_req and m_req held continuously (data requester re-requests after each valid), MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; if_valid occurs within 5 grants.
- Kill in flight: if_req granted (I_BUSY), if_kill pulsed before mem_ack -> bus completes, if_valid never asserts, next grant proceeds normally from IDLE.
- Wait states: mem_ack delayed 10 cycles -> mem_req/addr/we/be stable all 10 cycles; exactly one valid pulse; no duplicate issue when req is held through RESP.
- Reset mid-access: rst asserted during D_BUSY -> mem_req, m_valid, if_valid go to 0 asynchronously; after release the FSM is in IDLE with streak=0.
